// File: rtl/rx_packet_deframer.sv
// rx_packet_deframer: per-channel receive framer for the transceiver word stream.
// Locks on HEADER_WORD, captures the timestamp, forwards PAYLOAD_LEN payload
// words with sop/eop markers, checks ENDER_WORD and reports framing errors.
// Ports:
//   inclk, rst_n            clock, synchronous active-low reset
//   rx_syncstatus, rx_datak word-aligner lock and control-character flags
//   rx_data                 received parallel word
//   out_valid/out_data      payload word stream, out_sop/out_eop markers
//   out_timestamp           timestamp of the current packet
//   pkt_done/pkt_error      one-cycle packet close / abort pulses
//   err_code                cause of last error (01 ender, 10 sync, 11 datak)
//   seq_error               timestamp discontinuity, pulsed with pkt_done
//   pkt_count/err_count     saturating good-packet and error counters
module rx_packet_deframer #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           PAYLOAD_LEN = 125,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD = 16'hDEAD,
  parameter logic [DATA_WIDTH-1:0] ENDER_WORD  = 16'hBEEF
) (
  input  logic                  inclk,
  input  logic                  rst_n,
  input  logic [1:0]            rx_syncstatus,
  input  logic [1:0]            rx_datak,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_timestamp,
  output logic                  pkt_done,
  output logic                  pkt_error,
  output logic [1:0]            err_code,
  output logic                  seq_error,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_TS, S_PAYLOAD, S_END} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prev_ts_q, prev_ts_d;
  logic                  prev_vld_q, prev_vld_d;

  logic                  valid_d, sop_d, eop_d, done_d, error_d, seq_d;
  logic [DATA_WIDTH-1:0] data_d, ts_d;
  logic [1:0]            code_d;
  logic [15:0]           pc_d, ec_d;
  logic                  sync_ok, datak_ok;

  assign sync_ok  = (rx_syncstatus == 2'b11);
  assign datak_ok = (rx_datak == 2'b00);

  // State and registered outputs
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      prev_ts_q     <= '0;
      prev_vld_q    <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_timestamp <= '0;
      pkt_done      <= 1'b0;
      pkt_error     <= 1'b0;
      err_code      <= 2'b00;
      seq_error     <= 1'b0;
      pkt_count     <= '0;
      err_count     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_ts_q     <= prev_ts_d;
      prev_vld_q    <= prev_vld_d;
      out_valid     <= valid_d;
      out_data      <= data_d;
      out_sop       <= sop_d;
      out_eop       <= eop_d;
      out_timestamp <= ts_d;
      pkt_done      <= done_d;
      pkt_error     <= error_d;
      err_code      <= code_d;
      seq_error     <= seq_d;
      pkt_count     <= pc_d;
      err_count     <= ec_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_ts_d  = prev_ts_q;
    prev_vld_d = prev_vld_q;
    valid_d    = 1'b0;
    data_d     = out_data;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    ts_d       = out_timestamp;
    done_d     = 1'b0;
    error_d    = 1'b0;
    code_d     = err_code;
    seq_d      = 1'b0;
    pc_d       = pkt_count;
    ec_d       = err_count;

    // Link faults inside a packet abort it; sync loss outranks datak.
    if (state_q != S_IDLE && !(sync_ok && datak_ok)) begin
      error_d = 1'b1;
      code_d  = sync_ok ? 2'b11 : 2'b10;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sync_ok && datak_ok && rx_data == HEADER_WORD) state_d = S_TS;
        end
        S_TS: begin
          ts_d    = rx_data;
          cnt_d   = '0;
          state_d = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          valid_d = 1'b1;
          data_d  = rx_data;
          sop_d   = (cnt_q == '0);
          eop_d   = (cnt_q == LAST_IDX);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = S_END;
        end
        S_END: begin
          if (rx_data == ENDER_WORD) begin
            done_d     = 1'b1;
            // Wrap FFFF->0000 is in sequence via modular add.
            seq_d      = prev_vld_q && (out_timestamp != prev_ts_q + DATA_WIDTH'(1));
            prev_ts_d  = out_timestamp;
            prev_vld_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            error_d = 1'b1;
            code_d  = 2'b01;
            // A header in the ender slot starts the next packet immediately.
            state_d = (rx_data == HEADER_WORD) ? S_TS : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Saturating event counters
    if (done_d && pkt_count != 16'hFFFF)  pc_d = pkt_count + 16'd1;
    if (error_d && err_count != 16'hFFFF) ec_d = err_count + 16'd1;
  end

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Scoreboard bench for rx_packet_deframer: stimulus pushes expected payload
// words and packet events; a negedge monitor pops and compares.
module tb_rx_packet_deframer;

  localparam logic [15:0] HDR = 16'hDEAD;
  localparam logic [15:0] END = 16'hBEEF;
  localparam int NPAY = 125;

  logic        inclk = 1'b0;
  logic        rst_n;
  logic [1:0]  rx_syncstatus, rx_datak;
  logic [15:0] rx_data;
  logic        out_valid, out_sop, out_eop, pkt_done, pkt_error, seq_error;
  logic [15:0] out_data, out_timestamp, pkt_count, err_count;
  logic [1:0]  err_code;

  rx_packet_deframer dut (
    .inclk(inclk), .rst_n(rst_n), .rx_syncstatus(rx_syncstatus),
    .rx_datak(rx_datak), .rx_data(rx_data), .out_valid(out_valid),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_timestamp(out_timestamp), .pkt_done(pkt_done), .pkt_error(pkt_error),
    .err_code(err_code), .seq_error(seq_error), .pkt_count(pkt_count),
    .err_count(err_count)
  );

  always #5 inclk = ~inclk;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } pay_t;

  typedef struct {
    bit          done;
    logic [1:0]  code;
    logic        seq;
    logic [15:0] ts;
    logic [15:0] pc;
    logic [15:0] ec;
  } ev_t;

  pay_t pq[$];
  ev_t  eq[$];

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  logic [1:0] last_code = 2'b00;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented output against the queues
  always @(negedge inclk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (pq.size() == 0) chk("unexpected_out_valid", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          pay_t p;
          p = pq.pop_front();
          chk("out_data", 32'(out_data), 32'(p.data));
          chk("out_sop", 32'(out_sop), 32'(p.sop));
          chk("out_eop", 32'(out_eop), 32'(p.eop));
        end
      end
      if (pkt_done || pkt_error) begin
        chk("done_error_exclusive", 32'(pkt_done & pkt_error), 32'd0);
        if (eq.size() == 0) chk("unexpected_event", {30'd0, pkt_done, pkt_error}, 32'd0);
        else begin
          ev_t e;
          e = eq.pop_front();
          chk("pkt_done", 32'(pkt_done), 32'(e.done));
          chk("seq_error", 32'(seq_error), 32'(e.seq));
          chk("err_code", 32'(err_code), 32'(e.code));
          chk("pkt_count", 32'(pkt_count), 32'(e.pc));
          chk("err_count", 32'(err_count), 32'(e.ec));
          if (e.done) chk("out_timestamp", 32'(out_timestamp), 32'(e.ts));
        end
      end else if (seq_error) begin
        chk("seq_error_without_done", 32'(seq_error), 32'd0);
      end
    end
  end

  task automatic word(input logic [15:0] d, input logic [1:0] sync = 2'b11,
                      input logic [1:0] k = 2'b00);
    @(posedge inclk);
    #1;
    rx_data = d;
    rx_syncstatus = sync;
    rx_datak = k;
  endtask

  function automatic logic [15:0] pword(input int iter, input int i);
    return {8'(iter), 8'(i)};
  endfunction

  // Timestamp, payload and ender (no header, no gap)
  task automatic body(input logic [15:0] ts, input int iter, input logic [15:0] ender,
                      input logic exp_seq);
    ev_t e;
    word(ts);
    for (int i = 0; i < NPAY; i++) begin
      pq.push_back('{data: pword(iter, i), sop: (i == 0), eop: (i == NPAY - 1)});
      word(pword(iter, i));
    end
    if (ender == END) begin
      exp_pkt++;
      e = '{done: 1'b1, code: last_code, seq: exp_seq, ts: ts, pc: 16'(exp_pkt), ec: 16'(exp_err)};
    end else begin
      exp_err++;
      last_code = 2'b01;
      e = '{done: 1'b0, code: 2'b01, seq: 1'b0, ts: ts, pc: 16'(exp_pkt), ec: 16'(exp_err)};
    end
    eq.push_back(e);
    word(ender);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) word(16'h0000);
  endtask

  task automatic packet(input logic [15:0] ts, input int iter, input logic [15:0] ender,
                        input logic exp_seq);
    word(HDR);
    body(ts, iter, ender, exp_seq);
    gap(22);
  endtask

  // Packet aborted at position pos (0 = timestamp slot, k+1 = payload word k)
  task automatic abort_packet(input logic [15:0] ts, input int iter, input int pos,
                              input logic [1:0] sync, input logic [1:0] k,
                              input logic [1:0] exp_code);
    word(HDR);
    for (int p = 0; p <= NPAY; p++) begin
      logic [15:0] d;
      d = (p == 0) ? ts : pword(iter, p - 1);
      if (p == pos) begin
        exp_err++;
        last_code = exp_code;
        eq.push_back('{done: 1'b0, code: exp_code, seq: 1'b0, ts: ts,
                       pc: 16'(exp_pkt), ec: 16'(exp_err)});
        word(d, sync, k);
      end else begin
        if (p < pos && p > 0)
          pq.push_back('{data: d, sop: (p == 1), eop: 1'b0});
        word(d);
      end
    end
    word(END);
    gap(22);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_timestamp"}, 32'(out_timestamp), 32'd0);
    chk({tag, "_flags"}, {26'd0, out_sop, out_eop, pkt_done, pkt_error, seq_error, 1'b0}, 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx_syncstatus = 2'b11;
    rx_datak = 2'b00;
    rx_data = 16'h0000;
    repeat (3) @(posedge inclk);
    @(negedge inclk);
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    gap(4);

    // Nominal stream, consecutive timestamps
    packet(16'd10, 0, END, 1'b0);
    packet(16'd11, 1, END, 1'b0);
    packet(16'd12, 2, END, 1'b0);

    // Bad ender, then a good packet
    packet(16'd13, 3, 16'h1234, 1'b0);
    packet(16'd13, 4, END, 1'b0);

    // Header in ender slot: error then immediate resync to ts=20 (13 -> 20 jumps)
    word(HDR);
    body(16'd14, 5, HDR, 1'b0);
    body(16'd20, 6, END, 1'b1);
    gap(22);

    // Sync loss at payload word 50, then relock
    abort_packet(16'd21, 7, 51, 2'b01, 2'b00, 2'b10);
    packet(16'd21, 8, END, 1'b0);

    // Timestamp slot: sync loss with datak, then datak alone
    abort_packet(16'd22, 9, 0, 2'b01, 2'b01, 2'b10);
    abort_packet(16'd22, 10, 0, 2'b11, 2'b01, 2'b11);
    packet(16'd22, 11, END, 1'b0);

    // Reset mid-payload discards the packet silently
    word(HDR);
    word(16'd23);
    for (int i = 0; i < 30; i++) begin
      pq.push_back('{data: pword(12, i), sop: (i == 0), eop: 1'b0});
      word(pword(12, i));
    end
    word(pword(12, 30));
    rst_n = 1'b0;
    @(posedge inclk);
    @(negedge inclk);
    check_zero("midreset");
    rst_n = 1'b1;
    exp_pkt = 0;
    exp_err = 0;
    last_code = 2'b00;
    gap(4);

    // Sequence check after reset: 10, 11, 13
    packet(16'd10, 13, END, 1'b0);
    packet(16'd11, 14, END, 1'b0);
    packet(16'd13, 15, END, 1'b1);

    gap(4);
    @(negedge inclk);
    chk("final_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    chk("final_err_count", 32'(err_count), 32'(exp_err));
    chk("pay_queue_drained", pq.size(), 32'd0);
    chk("event_queue_drained", eq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
